// File: rtl/mant_shift_norm.sv
// ---------------------------------------------------------------------------
// mant_shift_norm
//
// Mantissa shift/normalise unit for the FP adder datapath. A mantissa is
// loaded in parallel, then one of two operations runs to completion under a
// start/busy/done handshake:
//   ALIGN - right shift by align_amt, ORing every bit lost on the right into
//           a sticky flag (exponent alignment).
//   NORM  - left shift until the MSB is set, counting the shifts in norm_cnt
//           (exponent adjust after subtraction).
//
// Build option:
//   MANT_SHIFT_FAST_ALIGN_EN - when defined, ALIGN completes in a single edge
//   through a barrel shifter and the ALIGN state is never entered. When
//   undefined, ALIGN shifts one bit per cycle.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset (0 = reset)
//   ld           parallel load of par_in (honoured only in IDLE)
//   par_in       mantissa to load
//   start_align  begin ALIGN (honoured only in IDLE)
//   align_amt    right-shift amount, sampled with start_align
//   start_norm   begin NORM (honoured only in IDLE)
//   mant_out     current mantissa register
//   sticky       OR of every bit shifted out on the right since the last ld
//   norm_cnt     left shifts performed by the last NORM
//   busy         high while in ALIGN or NORM
//   done         one-cycle completion pulse
//   zero         mant_out == 0
// ---------------------------------------------------------------------------
module mant_shift_norm #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [WIDTH-1:0]   par_in,
    input  logic               start_align,
    input  logic [SHAMT_W-1:0] align_amt,
    input  logic               start_norm,
    output logic [WIDTH-1:0]   mant_out,
    output logic               sticky,
    output logic [SHAMT_W-1:0] norm_cnt,
    output logic               busy,
    output logic               done,
    output logic               zero
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_NORM  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mant_q, mant_d;
    logic               sticky_q, sticky_d;
    logic [SHAMT_W-1:0] norm_cnt_q, norm_cnt_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

`ifdef MANT_SHIFT_FAST_ALIGN_EN
    // OR of the bits that the barrel shift drops off the right; an amount at
    // or beyond WIDTH drops every bit.
    logic lost_bits;

    always_comb begin
        lost_bits = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(align_amt)) begin
                lost_bits = lost_bits | mant_q[i];
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        sticky_d   = sticky_q;
        norm_cnt_d = norm_cnt_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    mant_d     = par_in;
                    sticky_d   = 1'b0;
                    norm_cnt_d = '0;
                end else if (start_align) begin
`ifdef MANT_SHIFT_FAST_ALIGN_EN
                    mant_d   = mant_q >> align_amt;
                    sticky_d = sticky_q | lost_bits;
                    state_d  = ST_DONE;
`else
                    if (align_amt == '0) begin
                        state_d = ST_DONE;
                    end else if (int'(align_amt) >= WIDTH) begin
                        // Everything falls off the right in one go.
                        mant_d   = '0;
                        sticky_d = sticky_q | (|mant_q);
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = align_amt;
                        state_d = ST_ALIGN;
                    end
`endif
                end else if (start_norm) begin
                    norm_cnt_d = '0;
                    // Zero can never normalise and an already-set MSB needs
                    // no shifting, so both finish immediately.
                    if ((mant_q == '0) || mant_q[WIDTH-1]) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end

            ST_ALIGN: begin
                mant_d   = {1'b0, mant_q[WIDTH-1:1]};
                sticky_d = sticky_q | mant_q[0];
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end

            ST_NORM: begin
                mant_d     = {mant_q[WIDTH-2:0], 1'b0};
                norm_cnt_d = norm_cnt_q + SHAMT_W'(1);
                // The bit about to become the MSB is already set, so this is
                // the last shift; this also caps NORM at WIDTH-1 shifts.
                if (mant_q[WIDTH-2]) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mant_q     <= '0;
            sticky_q   <= 1'b0;
            norm_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            sticky_q   <= sticky_d;
            norm_cnt_q <= norm_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mant_out = mant_q;
    assign sticky   = sticky_q;
    assign norm_cnt = norm_cnt_q;
    assign busy     = (state_q == ST_ALIGN) || (state_q == ST_NORM);
    assign done     = (state_q == ST_DONE);
    assign zero     = (mant_q == '0);

endmodule

// File: tb/tb_mant_shift_norm.sv
// ---------------------------------------------------------------------------
// tb_mant_shift_norm
//
// Directed bench for mant_shift_norm (WIDTH=24). A transaction-level model
// predicts the outputs from the arithmetic meaning of each command (final
// value = start >> k or start << k after k cycles), and a compare process
// checks every output against it on every cycle. Literal expectations pin
// both the DUT and the model at the key points.
// ---------------------------------------------------------------------------
module tb_mant_shift_norm;

    localparam int W  = 24;
    localparam int SW = 5;

`ifdef MANT_SHIFT_FAST_ALIGN_EN
    localparam int ALIGN4_BUSY = 0;
    localparam int ALIGN1_BUSY = 0;
`else
    localparam int ALIGN4_BUSY = 4;
    localparam int ALIGN1_BUSY = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ld = 1'b0;
    logic [W-1:0]  par_in = '0;
    logic          start_align = 1'b0;
    logic [SW-1:0] align_amt = '0;
    logic          start_norm = 1'b0;
    logic [W-1:0]  mant_out;
    logic          sticky;
    logic [SW-1:0] norm_cnt;
    logic          busy;
    logic          done;
    logic          zero;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    mant_shift_norm #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld          (ld),
        .par_in      (par_in),
        .start_align (start_align),
        .align_amt   (align_amt),
        .start_norm  (start_norm),
        .mant_out    (mant_out),
        .sticky      (sticky),
        .norm_cnt    (norm_cnt),
        .busy        (busy),
        .done        (done),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // Model state: phase 0 = idle, 1 = operation running, 2 = done cycle.
    logic [W-1:0]  m_mant = '0;
    logic [W-1:0]  m_base = '0;
    logic          m_sticky = 1'b0;
    logic          m_sticky_base = 1'b0;
    logic [SW-1:0] m_cnt = '0;
    int            m_phase = 0;
    bit            m_is_norm = 1'b0;
    int            m_k = 0;
    int            m_total = 0;
    int            m_amt = 0;

    // True if any of the low 'amt' bits of m is set.
    function automatic logic lostBits(logic [W-1:0] m, int amt);
        logic [63:0] mask;
        mask = (amt >= 64) ? '1 : ((64'd1 << amt) - 64'd1);
        return |({40'd0, m} & mask);
    endfunction

    // Number of leading zeros of a W-bit value.
    function automatic int leadZeros(logic [W-1:0] m);
        for (int i = W - 1; i >= 0; i--) begin
            if (m[i]) return W - 1 - i;
        end
        return W;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Advance the model on every rising edge using the inputs the DUT sees.
    // A command fixes its start value and length; the value shown k cycles
    // in is simply the start value shifted by k.
    always @(posedge clk) begin
        if (!rst) begin
            m_mant = '0;
            m_sticky = 1'b0;
            m_cnt = '0;
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (ld) begin
                        m_mant = par_in;
                        m_sticky = 1'b0;
                        m_cnt = '0;
                    end else if (start_align) begin
                        m_amt = int'(align_amt);
`ifdef MANT_SHIFT_FAST_ALIGN_EN
                        m_sticky = m_sticky | lostBits(m_mant, m_amt);
                        m_mant = (m_amt >= W) ? '0 : (m_mant >> m_amt);
                        m_phase = 2;
`else
                        if (m_amt == 0) begin
                            m_phase = 2;
                        end else if (m_amt >= W) begin
                            m_sticky = m_sticky | lostBits(m_mant, m_amt);
                            m_mant = '0;
                            m_phase = 2;
                        end else begin
                            m_base = m_mant;
                            m_sticky_base = m_sticky;
                            m_total = m_amt;
                            m_k = 0;
                            m_is_norm = 1'b0;
                            m_phase = 1;
                        end
`endif
                    end else if (start_norm) begin
                        m_cnt = '0;
                        if ((m_mant == '0) || m_mant[W-1]) begin
                            m_phase = 2;
                        end else begin
                            m_base = m_mant;
                            m_total = leadZeros(m_mant);
                            m_k = 0;
                            m_is_norm = 1'b1;
                            m_phase = 1;
                        end
                    end
                end
                1: begin
                    m_k++;
                    if (m_is_norm) begin
                        m_mant = m_base << m_k;
                        m_cnt = SW'(m_k);
                    end else begin
                        m_mant = m_base >> m_k;
                        m_sticky = m_sticky_base | lostBits(m_base, m_k);
                    end
                    if (m_k == m_total) m_phase = 2;
                end
                default: begin
                    m_phase = 0;
                end
            endcase
        end
    end

    // Every cycle, compare all DUT outputs with the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_mant", mant_out, m_mant);
            checkOutput("cyc_sticky", sticky, m_sticky);
            checkOutput("cyc_norm_cnt", norm_cnt, m_cnt);
            checkOutput("cyc_busy", busy, m_phase == 1);
            checkOutput("cyc_done", done, m_phase == 2);
            checkOutput("cyc_zero", zero, m_mant == '0);
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Present one set of inputs for exactly one rising edge.
    task automatic applyStimulus(input logic l, input logic [W-1:0] p,
                                 input logic sa, input logic [SW-1:0] amt,
                                 input logic sn);
        ld = l;
        par_in = p;
        start_align = sa;
        align_amt = amt;
        start_norm = sn;
        step();
        ld = 1'b0;
        par_in = '0;
        start_align = 1'b0;
        align_amt = '0;
        start_norm = 1'b0;
    endtask

    // Wait (bounded) for the done cycle, counting busy cycles on the way.
    task automatic waitDone(input int budget, output int nbusy);
        int cyc;
        nbusy = 0;
        cyc = 0;
        while ((done !== 1'b1) && (cyc < budget)) begin
            if (busy === 1'b1) nbusy++;
            step();
            cyc++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    // Directed scenario sequence.
    initial begin
        int nb;
        int seen;

        // Reset held for two edges.
        rst = 1'b0;
        step();
        step();
        checkOutput("rst_mant", mant_out, 0);
        checkOutput("rst_zero", zero, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        check_en = 1'b1;
        rst = 1'b1;
        step();

        // Parallel load.
        applyStimulus(1'b1, 24'h800001, 1'b0, '0, 1'b0);
        checkOutput("ld_mant", mant_out, 24'h800001);
        checkOutput("ld_sticky", sticky, 0);

        // Align by 4.
        applyStimulus(1'b1, 24'h80000F, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 5'd4, 1'b0);
        waitDone(40, nb);
        checkOutput("al4_busy_cycles", nb, ALIGN4_BUSY);
        checkOutput("al4_mant", mant_out, 24'h080000);
        checkOutput("al4_sticky", sticky, 1);
        checkOutput("al4_model", m_mant, 24'h080000);
        step();

        // Align by 0 leaves the mantissa alone.
        applyStimulus(1'b0, '0, 1'b1, 5'd0, 1'b0);
        waitDone(40, nb);
        checkOutput("al0_busy_cycles", nb, 0);
        checkOutput("al0_mant", mant_out, 24'h080000);
        step();

        // Align beyond the width.
        applyStimulus(1'b1, 24'h000001, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 5'd30, 1'b0);
        waitDone(40, nb);
        checkOutput("al30_busy_cycles", nb, 0);
        checkOutput("al30_mant", mant_out, 0);
        checkOutput("al30_sticky", sticky, 1);
        step();

        // Normalise 0x000300.
        applyStimulus(1'b1, 24'h000300, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitDone(60, nb);
        checkOutput("norm_busy_cycles", nb, 14);
        checkOutput("norm_mant", mant_out, 24'hC00000);
        checkOutput("norm_cnt", norm_cnt, 14);
        checkOutput("norm_model", m_mant, 24'hC00000);
        step();

        // Normalise zero.
        applyStimulus(1'b1, 24'h000000, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitDone(40, nb);
        checkOutput("norm0_busy_cycles", nb, 0);
        checkOutput("norm0_cnt", norm_cnt, 0);
        checkOutput("norm0_zero", zero, 1);
        step();

        // Commands arriving while an align is in flight are dropped.
        applyStimulus(1'b1, 24'h80000F, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 5'd4, 1'b0);
`ifdef MANT_SHIFT_FAST_ALIGN_EN
        checkOutput("prot_done", done, 1);
        applyStimulus(1'b1, 24'h123456, 1'b0, '0, 1'b1);
`else
        checkOutput("prot_busy", busy, 1);
        applyStimulus(1'b1, 24'h123456, 1'b0, '0, 1'b1);
        waitDone(40, nb);
        step();
`endif
        checkOutput("prot_mant", mant_out, 24'h080000);
        checkOutput("prot_sticky", sticky, 1);
        checkOutput("prot_idle", busy, 0);

        // Simultaneous start_align and start_norm: align wins.
        applyStimulus(1'b1, 24'h000002, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 5'd1, 1'b1);
        waitDone(40, nb);
        checkOutput("both_busy_cycles", nb, ALIGN1_BUSY);
        checkOutput("both_mant", mant_out, 24'h000001);
        checkOutput("both_sticky", sticky, 0);
        step();

        // Reset during the third NORM cycle.
        applyStimulus(1'b1, 24'h000300, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checkOutput("mid_rst_mant", mant_out, 0);
        checkOutput("mid_rst_cnt", norm_cnt, 0);
        checkOutput("mid_rst_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (done === 1'b1) seen++;
            step();
        end
        checkOutput("mid_rst_no_done", seen, 0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mant_shift_norm.md
Name: mant_shift_norm

Overview:
- Parametrised successor to the fixed 24-bit mantissa shift register in the FP adder datapath.
- Loads a mantissa in parallel, then runs one of two sequential operations:
  - ALIGN: right-shift by a requested amount with sticky-bit capture, used for exponent alignment.
  - NORM: left-shift until the MSB is 1, counting the shifts for the exponent adjust.
- Has a start/busy/done handshake so the adder controller issues one command and waits for completion.

Parameters:
- WIDTH, 24, mantissa width in bits (>=4).
- SHAMT_W, 5, width of the shift-amount and count fields; 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- ld  input  1  parallel load of par_in, accepted only in IDLE.
- par_in  input  WIDTH  mantissa to load.
- start_align  input  1  begin ALIGN, accepted only in IDLE.
- align_amt  input  SHAMT_W  right-shift amount, sampled with start_align.
- start_norm  input  1  begin NORM, accepted only in IDLE.
- mant_out  output  WIDTH  current mantissa register.
- sticky  output  1  OR of every bit shifted out on the right since the last ld.
- norm_cnt  output  SHAMT_W  left shifts performed by the last NORM.
- busy  output  1  high in ALIGN or NORM.
- done  output  1  one-cycle completion pulse.
- zero  output  1  combinational: mant_out == 0.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, mant_out=0, sticky=0, norm_cnt=0, internal counter=0. Consequently busy=0, done=0, zero=1. Reset overrides everything, including an operation in progress.
- States: IDLE, ALIGN, NORM, DONE. busy = (state is ALIGN or NORM); done = (state is DONE). Both are state-decoded.
- IDLE priority, highest first: ld > start_align > start_norm. Only one action is taken per edge.
- ld in IDLE: mant_out<=par_in, sticky<=0, norm_cnt<=0; stay in IDLE; no done pulse.
- start_align in IDLE:
  - align_amt==0: go to DONE; mantissa unchanged.
  - align_amt>=WIDTH: mant_out<=0, sticky<=sticky | (OR of mant_out), go to DONE.
  - Otherwise: cnt<=align_amt, go to ALIGN.
- ALIGN, every edge: mant_out<={0,mant_out[WIDTH-1:1]}, sticky<=sticky|mant_out[0], cnt<=cnt-1. When cnt==1, go to DONE on the same edge.
- ALIGN latency: amt shifts on edges 1..amt after the start edge; done is high in the cycle after edge amt.
- start_norm in IDLE:
  - mant_out==0: norm_cnt<=0, go to DONE (zero stays 1).
  - mant_out[WIDTH-1]==1: norm_cnt<=0, go to DONE.
  - Otherwise: norm_cnt<=0, go to NORM.
- NORM, every edge: mant_out<={mant_out[WIDTH-2:0],0}, norm_cnt<=norm_cnt+1. When mant_out[WIDTH-2]==1, go to DONE on the same edge. sticky is unchanged.
- NORM bound: at most WIDTH-1 shifts; norm_cnt never wraps.
- DONE: always returns to IDLE on the next edge. ld and start inputs are ignored while in DONE.
- While busy: ld, start_align and start_norm are ignored, with no queuing.
- Simultaneous start_align and start_norm: ALIGN only.
- mant_out holds its value in every state or cycle not listed above.

Optional Feature:
- Macro MANT_SHIFT_FAST_ALIGN_EN.
- Defined: ALIGN completes in one edge via a barrel shifter. mant_out<=mant_out>>align_amt, sticky<=sticky | OR of the shifted-out bits, go to DONE, so done is high in the cycle after the start edge for any align_amt. The ALIGN state is unused.
- Undefined: iterative one-bit-per-cycle ALIGN exactly as above.
- NORM is identical in both builds.

Test Plan (WIDTH=24, default build unless noted):
- Reset/load: rst=0 for 2 cycles -> mant_out=0, zero=1, busy=0, done=0. Then ld with par_in=0x800001 -> mant_out=0x800001, sticky=0.
- Align: load 0x80000F, start_align amt=4 -> busy for 4 cycles, then done pulse. mant_out=0x080000, sticky=1. With MANT_SHIFT_FAST_ALIGN_EN, same result with done one cycle after start.
- Align edges:
  - amt=0 -> done next cycle, mant unchanged.
  - Load 0x000001, amt=30 -> mant_out=0, sticky=1, done next cycle.
- Normalize: load 0x000300, start_norm -> 14 busy cycles, mant_out=0xC00000, norm_cnt=14, done pulse. Load 0x000000, start_norm -> done next cycle, norm_cnt=0, zero=1.
- Protocol: during ALIGN, pulse ld=0x123456 and start_norm -> both ignored and the align result is unchanged. Simultaneous start_align amt=1 and start_norm on 0x000002 -> right shift performed, mant_out=0x000001.
- Reset mid-operation: rst=0 on the 3rd cycle of NORM -> next cycle mant_out=0, norm_cnt=0, busy=0, done never asserted.
